// File: rtl/sb_pkg.sv
// Shared types for the store buffer: buffered entry layout, drain FSM
// state encoding and the "no bytes enabled" constant.
package sb_pkg;

  // Word-address field width for a 32-bit byte address space.
  localparam int SB_WADDR_W = 30;

  // A store with no byte lanes enabled completes its handshake but is dropped.
  localparam logic [3:0] BYTEEN_NONE = 4'b0000;

  typedef enum logic {
    SB_IDLE = 1'b0,
    SB_BUSY = 1'b1
  } sb_state_e;

  // One buffered store: word address, lane-aligned data, byte enables.
  typedef struct packed {
    logic [SB_WADDR_W-1:0] waddr;
    logic [31:0]           wdata;
    logic [3:0]            byteen;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_ctrl_if.sv
// Pipeline-side and memory-side signals of the store buffer.
//
// Handshakes:
//   store : a store transfers on a rising edge where st_valid && st_ready.
//           st_ready depends only on registered occupancy.
//   memory: mem_req/mem_addr/mem_wdata/mem_byteen stay stable from the
//           first request cycle until the edge where mem_req && mem_ack;
//           that edge completes the write. mem_ack without mem_req is ignored.
//   load  : ld_stall is a combinational reply to ld_valid/ld_addr.
interface store_buffer_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              st_valid;
  logic [ADDR_W-1:0] st_addr;
  logic [31:0]       st_wdata;
  logic [3:0]        st_byteen;
  logic              st_ready;
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic              ld_stall;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_byteen;
  logic              mem_ack;
  logic              empty;

  // Store buffer side.
  modport slave (
    input  st_valid, st_addr, st_wdata, st_byteen, ld_valid, ld_addr, mem_ack,
    output st_ready, ld_stall, mem_req, mem_addr, mem_wdata, mem_byteen, empty
  );

  // Pipeline / memory side.
  modport master (
    output st_valid, st_addr, st_wdata, st_byteen, ld_valid, ld_addr, mem_ack,
    input  st_ready, ld_stall, mem_req, mem_addr, mem_wdata, mem_byteen, empty
  );
endinterface

// File: rtl/store_buffer_ctrl_fifo.sv
// In-order storage for buffered stores. Keeps pointers, occupancy and a
// valid bit per slot, and exposes every slot for the load address compare.
module store_buf_fifo
  import sb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n_i,
  input  logic                     push_i,
  input  sb_entry_t                push_entry_i,
  input  logic                     pop_i,
  output sb_entry_t [DEPTH-1:0]    entries_o,
  output logic [DEPTH-1:0]         valid_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output sb_entry_t                head_o,
  output sb_entry_t                next_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  sb_entry_t [DEPTH-1:0] mem_q;
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [PW-1:0]         rptr_q, wptr_q;
  logic [CW-1:0]         count_q, count_d;

  // Next occupancy and slot-valid bits from this cycle's push/pop.
  always_comb begin
    count_d = count_q;
    valid_d = valid_q;
    if (push_i && !pop_i) count_d = count_q + CW'(1);
    if (pop_i && !push_i) count_d = count_q - CW'(1);
    if (pop_i)  valid_d[rptr_q] = 1'b0;
    if (push_i) valid_d[wptr_q] = 1'b1;
  end

  // Storage, pointers (wrap by natural overflow of a power-of-two range), count.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mem_q   <= '0;
      valid_q <= '0;
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wptr_q] <= push_entry_i;
        wptr_q        <= wptr_q + PW'(1);
      end
      if (pop_i) rptr_q <= rptr_q + PW'(1);
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign entries_o = mem_q;
  assign valid_o   = valid_q;
  assign count_o   = count_q;
  assign head_o    = mem_q[rptr_q];
  assign next_o    = mem_q[rptr_q + PW'(1)];

endmodule

// File: rtl/store_buffer_ctrl.sv
// Store buffer controller: absorbs M-stage stores into a small FIFO, drains
// them one at a time over a req/ack memory bus, and stalls loads that hit a
// word still pending in the buffer.
module store_buffer_ctrl
  import sb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  store_buffer_ctrl_if.slave      sb,
  output sb_state_e               dbg_state_o,
  output logic [$clog2(DEPTH):0]  dbg_count_o
);
  localparam int CW = $clog2(DEPTH) + 1;

  sb_entry_t [DEPTH-1:0] entries;
  logic [DEPTH-1:0]      valid;
  logic [CW-1:0]         count;
  sb_entry_t             head, next, follow, push_entry;
  logic                  push, pop, hit;

  sb_state_e             state_q;
  logic                  mem_req_q;
  logic [ADDR_W-3:0]     mem_waddr_q;
  logic [31:0]           mem_wdata_q;
  logic [3:0]            mem_byteen_q;

  // Accept whenever not full (registered count); drop stores with no lanes.
  assign sb.st_ready = (count < CW'(DEPTH));
  assign push        = sb.st_valid && sb.st_ready && (sb.st_byteen != BYTEEN_NONE);
  assign pop         = (state_q == SB_BUSY) && sb.mem_ack;

  assign push_entry = '{waddr:  SB_WADDR_W'(sb.st_addr[ADDR_W-1:2]),
                        wdata:  sb.st_wdata,
                        byteen: sb.st_byteen};

  // Entry presented after a pop: the second-oldest if one exists, otherwise
  // the store being written this very cycle into the slot behind the head.
  assign follow = (count > CW'(1)) ? next : push_entry;

  store_buf_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst_n_i      (reset),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .entries_o    (entries),
    .valid_o      (valid),
    .count_o      (count),
    .head_o       (head),
    .next_o       (next)
  );

  // Drain FSM with registered bus outputs; back-to-back requests when more
  // entries remain after an ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= SB_IDLE;
      mem_req_q    <= 1'b0;
      mem_waddr_q  <= '0;
      mem_wdata_q  <= '0;
      mem_byteen_q <= '0;
    end else begin
      case (state_q)
        SB_IDLE: begin
          if (count != '0) begin
            state_q      <= SB_BUSY;
            mem_req_q    <= 1'b1;
            mem_waddr_q  <= head.waddr[ADDR_W-3:0];
            mem_wdata_q  <= head.wdata;
            mem_byteen_q <= head.byteen;
          end
        end
        SB_BUSY: begin
          if (sb.mem_ack) begin
            if ((count > CW'(1)) || push) begin
              mem_waddr_q  <= follow.waddr[ADDR_W-3:0];
              mem_wdata_q  <= follow.wdata;
              mem_byteen_q <= follow.byteen;
            end else begin
              state_q      <= SB_IDLE;
              mem_req_q    <= 1'b0;
              mem_waddr_q  <= '0;
              mem_wdata_q  <= '0;
              mem_byteen_q <= '0;
            end
          end
        end
        default: state_q <= SB_IDLE;
      endcase
    end
  end

  // Parallel word-address compare against every registered valid entry.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (entries[i].waddr == SB_WADDR_W'(sb.ld_addr[ADDR_W-1:2])))
        hit = 1'b1;
    end
  end

  assign sb.ld_stall   = sb.ld_valid && hit;
  assign sb.mem_req    = mem_req_q;
  assign sb.mem_addr   = {mem_waddr_q, 2'b00};
  assign sb.mem_wdata  = mem_wdata_q;
  assign sb.mem_byteen = mem_byteen_q;
  assign sb.empty      = (count == '0) && (state_q == SB_IDLE);
  assign dbg_state_o   = state_q;
  assign dbg_count_o   = count;

endmodule

// File: tb/tb_store_buffer_ctrl.sv
// Bench for store_buffer_ctrl: directed scenarios plus a random phase,
// checked by a per-cycle queue model and an ack-time write scoreboard.
module tb_store_buffer_ctrl;
  import sb_pkg::*;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;

  logic      clk = 1'b0;
  logic      reset = 1'b0;
  sb_state_e dbg_state;
  logic [$clog2(DEPTH):0] dbg_count;

  store_buffer_ctrl_if #(.ADDR_W(ADDR_W)) sb();

  store_buffer_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .sb          (sb),
    .dbg_state_o (dbg_state),
    .dbg_count_o (dbg_count)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [67:0] exp_q[$];   // {byte addr word-aligned, wdata, byteen}, in write order
  logic [67:0] mdl_q[$];   // model of buffered contents
  bit          mdl_busy;
  int          checks = 0;
  int          errors = 0;
  int          ack_mode = 0;  // 0 low, 1 high, 2 random, 3 ack on 3rd req cycle, 4 one-shot, 5 toggle

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory ack driver ----------------
  initial begin : ack_drv
    int age;
    age = 0;
    sb.mem_ack = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      case (ack_mode)
        0: sb.mem_ack = 1'b0;
        1: sb.mem_ack = 1'b1;
        2: sb.mem_ack = 1'($urandom_range(0, 1));
        3: sb.mem_ack = sb.mem_req && (age >= 2);
        4: begin
          sb.mem_ack = sb.mem_req;
          if (sb.mem_req) ack_mode = 0;
        end
        default: sb.mem_ack = ~sb.mem_ack;
      endcase
      if (sb.mem_req && !sb.mem_ack) age++;
      else age = 0;
    end
  end

  // ---------------- monitor + reference model ----------------
  initial begin : monitor
    logic [67:0] e;
    bit hit, push, pop;
    int was_size;
    mdl_busy = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!reset) begin
        mdl_q.delete();
        exp_q.delete();
        mdl_busy = 0;
        chk("reset_req", sb.mem_req, 0);
        chk("reset_empty", sb.empty, 1);
        chk("reset_ready", sb.st_ready, 1);
        chk("reset_stall", sb.ld_stall, 0);
      end else begin
        chk("st_ready", sb.st_ready, mdl_q.size() < DEPTH);
        chk("count", dbg_count, mdl_q.size());
        chk("mem_req", sb.mem_req, mdl_busy);
        chk("state", dbg_state, mdl_busy ? SB_BUSY : SB_IDLE);
        chk("empty", sb.empty, (mdl_q.size() == 0) && !mdl_busy);
        hit = 0;
        foreach (mdl_q[i]) if (mdl_q[i][67:38] == sb.ld_addr[31:2]) hit = 1;
        chk("ld_stall", sb.ld_stall, sb.ld_valid && hit);
        if (mdl_busy && mdl_q.size() > 0)
          chk("mem_head", {sb.mem_addr, sb.mem_wdata, sb.mem_byteen}, mdl_q[0]);
        if (sb.mem_req && sb.mem_ack) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mem_write unexpected actual=%0h required=none", sb.mem_addr);
          end else begin
            e = exp_q.pop_front();
            chk("mem_write", {sb.mem_addr, sb.mem_wdata, sb.mem_byteen}, e);
          end
        end
        // Advance the model across the coming edge.
        push = sb.st_valid && (mdl_q.size() < DEPTH) && (sb.st_byteen != 4'b0000);
        pop  = mdl_busy && sb.mem_ack;
        was_size = mdl_q.size();
        if (pop)  void'(mdl_q.pop_front());
        if (push) mdl_q.push_back({sb.st_addr & ~32'h3, sb.st_wdata, sb.st_byteen});
        if (!mdl_busy) mdl_busy = (was_size > 0);
        else if (pop)  mdl_busy = (mdl_q.size() > 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    int n;
    sb.st_valid = 1'b1; sb.st_addr = a; sb.st_wdata = d; sb.st_byteen = b;
    n = 0;
    #1;
    while (!sb.st_ready && n < 64) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb.st_ready) begin
      if (b != 4'b0000) exp_q.push_back({a & ~32'h3, d, b});
    end else begin
      checks++;
      errors++;
      $display("FAIL store_accept timeout actual=0 required=1 addr=%0h", a);
    end
    @(negedge clk);
    sb.st_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    @(negedge clk);
    #1;
    while (!sb.empty && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("drain_empty", sb.empty, 1);
    chk("drain_queue", exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin : driver
    int n;
    sb.st_valid = 0; sb.st_addr = '0; sb.st_wdata = '0; sb.st_byteen = '0;
    sb.ld_valid = 0; sb.ld_addr = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Single store, ack two cycles into the request.
    ack_mode = 3;
    do_store(32'h0000_1004, 32'h1122_3344, 4'b1111);
    wait_empty();

    // Fill, refuse a fifth store, one ack frees a slot, then drain.
    ack_mode = 0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) do_store(32'h300 + 32'(i * 4), 32'hA000_0000 + 32'(i), 4'hF);
    sb.st_valid = 1; sb.st_addr = 32'h340; sb.st_wdata = 32'hA000_0004; sb.st_byteen = 4'hF;
    repeat (3) @(negedge clk);
    #1;
    chk("full_ready", sb.st_ready, 0);
    ack_mode = 4;
    do_store(32'h340, 32'hA000_0004, 4'hF);
    ack_mode = 1;
    wait_empty();

    // Zero byte-enable store handshakes but is not buffered.
    do_store(32'h500, 32'hDEAD_BEEF, 4'b0000);
    wait_empty();

    // Back-to-back drain of three stores.
    ack_mode = 0;
    for (int i = 0; i < 3; i++) do_store(32'h400 + 32'(i * 8), 32'hB000_0000 + 32'(i), 4'(i + 1));
    ack_mode = 1;
    wait_empty();

    // Load hazard on a pending partial-word store.
    ack_mode = 0;
    do_store(32'h2002, 32'h0055_0000, 4'b0100);
    sb.ld_valid = 1; sb.ld_addr = 32'h2000;
    repeat (3) @(negedge clk);
    #1;
    chk("hazard_hit", sb.ld_stall, 1);
    sb.ld_addr = 32'h2004;
    #1;
    chk("hazard_miss", sb.ld_stall, 0);
    sb.ld_addr = 32'h2000;
    ack_mode = 1;
    wait_empty();
    sb.ld_valid = 0;

    // Six stores with alternating acks: wrap plus simultaneous push/pop.
    ack_mode = 5;
    for (int i = 0; i < 6; i++) do_store(32'h600 + 32'(i * 4), 32'hC000_0000 + 32'(i), 4'hF);
    ack_mode = 1;
    wait_empty();

    // Reset in the middle of a request.
    ack_mode = 0;
    do_store(32'h700, 32'h1, 4'hF);
    do_store(32'h704, 32'h2, 4'hF);
    n = 0;
    #1;
    while (!sb.mem_req && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("pre_reset_req", sb.mem_req, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_req", sb.mem_req, 0);
    chk("async_reset_empty", sb.empty, 1);
    chk("async_reset_count", dbg_count, 0);
    ack_mode = 1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    ack_mode = 0;

    // Random traffic on a small address window so hazards are common.
    ack_mode = 2;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      sb.st_valid  = ($urandom_range(0, 2) == 0);
      sb.st_addr   = 32'h100 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
      sb.st_wdata  = $urandom;
      sb.st_byteen = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      sb.ld_valid  = ($urandom_range(0, 1) == 1);
      sb.ld_addr   = 32'h100 + 32'($urandom_range(0, 9) * 4);
      #1;
      if (sb.st_valid && sb.st_ready && sb.st_byteen != 4'b0000)
        exp_q.push_back({sb.st_addr & ~32'h3, sb.st_wdata, sb.st_byteen});
    end
    @(negedge clk);
    sb.st_valid = 0;
    sb.ld_valid = 0;
    ack_mode = 1;
    wait_empty();

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_buffer_ctrl.md
Name: store_buffer_ctrl

Overview:
- Write buffer and sequencer between the M-stage store data path (aligned write data + byte enables) and a data memory bus with multi-cycle req/ack latency.
- Absorbs stores into a small in-order FIFO so the pipeline need not wait on memory.
- Drains entries to the memory bus one at a time under a req/ack handshake.
- Stalls M-stage loads that hit a word still pending in the buffer.

Parameters:
DEPTH, 4, number of buffered stores; power of two, >= 2
ADDR_W, 32, byte address width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
st_valid  in  1  M-stage store present this cycle
st_addr  in  ADDR_W  store byte address; bits [1:0] ignored for buffering
st_wdata  in  32  lane-aligned store data
st_byteen  in  4  byte enables for st_wdata
st_ready  out  1  buffer can accept a store this cycle
ld_valid  in  1  M-stage load present this cycle
ld_addr  in  ADDR_W  load byte address
ld_stall  out  1  load must hold in M; combinational
mem_req  out  1  write request to data memory
mem_addr  out  ADDR_W  word address, bits [1:0] = 0
mem_wdata  out  32  write data
mem_byteen  out  4  write byte enables
mem_ack  in  1  memory accepted the current request
empty  out  1  no buffered stores and no request outstanding

Behaviour:
- Reset (reset=0, async): count=0; rptr=wptr=0; all entry valid bits cleared; FSM=IDLE; mem_req=0; mem_addr/mem_wdata/mem_byteen=0; st_ready=1; ld_stall=0; empty=1. An in-flight request is abandoned; an ack arriving during or after reset is ignored.
- Entry fields: {addr[ADDR_W-1:2], wdata, byteen}.
- Enqueue:
  - Occurs when st_valid && st_ready && st_byteen!=0; writes at wptr; wptr wraps modulo DEPTH.
  - A store with st_byteen==0 is accepted (handshake completes) but not buffered.
  - st_ready = (count < DEPTH). Registered-count based: no same-cycle pass-through when full, even if mem_ack pops that cycle.
- Drain FSM, two states:
  - IDLE: mem_req=0. Go to BUSY at the next edge if count>0.
  - BUSY: mem_req=1. mem_addr/mem_wdata/mem_byteen = entry at rptr, stable until mem_ack.
  - On mem_ack in BUSY: pop the head (rptr wraps modulo DEPTH). If count-after-update > 0, stay BUSY with the new head presented the next cycle (back-to-back, no bubble). Otherwise return to IDLE.
  - mem_ack while IDLE is ignored.
- Latency: a store enqueued into an empty buffer at edge N gives mem_req=1 in the cycle after edge N+1 (one IDLE cycle, then BUSY).
- Simultaneous enqueue and pop: count unchanged; both pointers advance.
- Load hazard:
  - ld_stall = ld_valid && (any valid entry with addr == ld_addr[ADDR_W-1:2]), comparing registered entries only. The head being acked this cycle still counts.
  - A store and a load in the same cycle is not a legal pipeline state. If it occurs, the store enqueues and the load check ignores it.
- empty = (count==0) && (FSM==IDLE).
- Count width is log2(DEPTH)+1; never exceeds DEPTH, never underflows.

Decomposition:
- Shared package sb_pkg: entry struct (word addr, wdata, byteen); FSM state enum {SB_IDLE, SB_BUSY}; constant BYTEEN_NONE=4'b0000.
- One natural sub-module: store_buf_fifo. It holds the storage array, pointers, count and valid bits, and exposes all entries for the parallel address compare.
- The FSM and hazard logic stay in store_buffer_ctrl.

Test Plan:
- Single store: addr 0x0000_1004, wdata 0x1122_3344, byteen 4'b1111, mem_ack 2 cycles after mem_req -> mem_req rises 2 edges after enqueue; mem_addr=0x1004; held stable until ack; then empty=1.
- Fill: 4 stores with mem_ack=0 -> st_ready=0 after 4th; 5th st_valid not accepted; single ack -> st_ready=1 next cycle; order preserved.
- Back-to-back drain: 3 buffered stores, mem_ack held 1 -> three consecutive mem_req cycles with addrs in enqueue order, then IDLE.
- Load hazard: store 0x2002 byteen 4'b0100 pending; ld_addr 0x2000 -> ld_stall=1 until that entry's ack edge; ld_addr 0x2004 -> ld_stall=0.
- Wrap/simultaneous: 6 stores with ack every other cycle -> pointers wrap; count is correct on enqueue+pop cycles; all 6 written in order.
- Reset mid-request: mem_req=1 with 2 entries, drive reset=0 -> mem_req=0 immediately; empty=1; later ack ignored.
